iob_be_mem_arbiter: RTL and testbench

//  Shares one single-port byte-enable back-end RAM (iob_ram_sp_be, 1-cycle read) between two IOb

---
 rtl/iob_be_mem_arbiter_if.sv | 34 +++
 rtl/iob_be_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_iob_be_mem_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_be_mem_arbiter_if.sv
// IOb back-end request/response bundle for one master.
// master drives valid/addr/wdata/wstrb; slave returns ready/rvalid/rdata.
interface iob_be_mem_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) ();
  logic                  iob_valid;
  logic [ADDR_W-1:0]     iob_addr;
  logic [DATA_W-1:0]     iob_wdata;
  logic [DATA_W/8-1:0]   iob_wstrb;
  logic                  iob_ready;
  logic                  iob_rvalid;
  logic [DATA_W-1:0]     iob_rdata;

  modport master (
    output iob_valid,
    output iob_addr,
    output iob_wdata,
    output iob_wstrb,
    input  iob_ready,
    input  iob_rvalid,
    input  iob_rdata
  );

  modport slave (
    input  iob_valid,
    input  iob_addr,
    input  iob_wdata,
    input  iob_wstrb,
    output iob_ready,
    output iob_rvalid,
    output iob_rdata
  );
endinterface

// File: rtl/iob_be_mem_arbiter.sv
// Two-master round-robin arbiter with bounded burst lock onto one
// single-port byte-enable RAM (1-cycle read).
// Ports: clk_i, rst_i (sync, active-high), cke_i (stall when low),
//   m0/m1 (IOb slave modports), mem_en_o/mem_we_o/mem_addr_o/mem_d_o
//   to the RAM, mem_d_i read data back from the RAM.
module iob_be_mem_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,
  iob_be_mem_arbiter_if.slave m0,
  iob_be_mem_arbiter_if.slave m1,
  output logic                mem_en_o,
  output logic [DATA_W/8-1:0] mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_d_o,
  input  logic [DATA_W-1:0]   mem_d_i
);

  localparam int CNT_W  = $clog2(MAX_BURST + 1);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] MAXC =
    CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_BURST,
    PH_SAT
  } phase_e;

  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_id_q, rd_id_d;

  phase_e           phase;
  logic             gnt;
  logic             g;
  logic             own_v;
  logic             xfer;
  logic             rv;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  always_comb begin
    phase = PH_BURST;
    if (cnt_q == '0) begin
      phase = PH_IDLE;
    end else if (cnt_q >= MAXC) begin
      phase = PH_SAT;
    end
  end

  assign own_v = last_q ? m1.iob_valid
                        : m0.iob_valid;

  // Mid-burst the owner keeps the RAM while it
  // still requests; otherwise alternate on a tie.
  always_comb begin
    gnt = 1'b0;
    g   = last_q;
    if (phase == PH_BURST && own_v) begin
      gnt = 1'b1;
      g   = last_q;
    end else if (m0.iob_valid && m1.iob_valid) begin
      gnt = 1'b1;
      g   = ~last_q;
    end else if (m0.iob_valid) begin
      gnt = 1'b1;
      g   = 1'b0;
    end else if (m1.iob_valid) begin
      gnt = 1'b1;
      g   = 1'b1;
    end
  end

  assign xfer = gnt & cke_i & ~rst_i;

  assign sel_addr  = g ? m1.iob_addr  : m0.iob_addr;
  assign sel_wdata = g ? m1.iob_wdata : m0.iob_wdata;
  assign sel_wstrb = g ? m1.iob_wstrb : m0.iob_wstrb;

  assign mem_en_o   = xfer;
  assign mem_we_o   = xfer ? sel_wstrb : '0;
  assign mem_addr_o = xfer ? sel_addr  : '0;
  assign mem_d_o    = xfer ? sel_wdata : '0;

  assign m0.iob_ready = xfer & ~g;
  assign m1.iob_ready = xfer &  g;

  // Reset kills a read response in the same cycle.
  assign rv = rd_pend_q & ~rst_i;

  assign m0.iob_rvalid = rv & ~rd_id_q;
  assign m1.iob_rvalid = rv &  rd_id_q;
  assign m0.iob_rdata  = mem_d_i;
  assign m1.iob_rdata  = mem_d_i;

  always_comb begin
    last_d    = last_q;
    cnt_d     = cnt_q;
    rd_pend_d = rd_pend_q;
    rd_id_d   = rd_id_q;
    if (cke_i) begin
      if (xfer) begin
        last_d    = g;
        rd_pend_d = ~|sel_wstrb;
        rd_id_d   = g;
        if (g == last_q && cnt_q < MAXC) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = CNT_W'(1);
        end
      end else begin
        // An idle cycle releases any lock.
        cnt_d     = '0;
        rd_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= 1'b0;
    end else begin
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

endmodule

// File: tb/tb_iob_be_mem_arbiter.sv
// Self-checking bench for iob_be_mem_arbiter: directed scenarios
// plus randomized traffic against a streak-based reference model.
module tb_iob_be_mem_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int MB = 4;

  typedef logic [96:0] obs_t;

  logic clk;
  logic rst;
  logic cke;

  iob_be_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  iob_be_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] mem_din;

  iob_be_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke),
    .m0(m0_if), .m1(m1_if),
    .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_d_o(mem_dout),
    .mem_d_i(mem_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM environment (iob_ram_sp_be behaviour) with a backdoor port.
  logic [31:0] ram [256];
  logic [31:0] ram_q;
  logic        fill;
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  function automatic logic [31:0] pat(int i);
    return {8'hC0, i[7:0], ~i[7:0], 8'(i * 7)};
  endfunction

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
    end else if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (mem_en) begin
      if (|mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_dout[8*b +: 8];
      end else begin
        ram_q <= ram[mem_addr[7:0]];
      end
    end
  end
  assign mem_din = ram_q;

  // Reference model: who owns the RAM, how long its streak of
  // back-to-back transfers is, and the read awaiting its response.
  logic [31:0] shadow [256];
  bit          m_last;
  int          m_run;
  bit          m_pend;
  bit          m_pend_id;
  logic [31:0] m_pend_data;

  bit          e_g;
  bit          e_x;
  logic [23:0] e_a;
  logic [31:0] e_wd;
  logic [3:0]  e_s;
  obs_t        exp_obs;

  int nvec;
  int nerr;

  function automatic obs_t observe();
    logic [31:0] rd;
    rd = m0_if.iob_rvalid ? m0_if.iob_rdata :
         m1_if.iob_rvalid ? m1_if.iob_rdata : 32'h0;
    return {m0_if.iob_ready, m1_if.iob_ready, mem_en,
            m0_if.iob_rvalid, m1_if.iob_rvalid,
            mem_en ? mem_addr : 24'h0,
            mem_en ? mem_we : 4'h0,
            mem_en ? mem_dout : 32'h0, rd};
  endfunction

  task automatic model_eval();
    logic v0, v1, gnt, rv;
    v0  = m0_if.iob_valid;
    v1  = m1_if.iob_valid;
    gnt = 1'b0;
    e_g = 1'b0;
    if (m_run > 0 && m_run < MB && (m_last ? v1 : v0)) begin
      gnt = 1'b1; e_g = m_last;
    end else if (v0 && v1) begin
      gnt = 1'b1; e_g = !m_last;
    end else if (v0 || v1) begin
      gnt = 1'b1; e_g = v1 && !v0;
    end
    e_x  = gnt && cke && !rst;
    e_a  = e_g ? m1_if.iob_addr  : m0_if.iob_addr;
    e_wd = e_g ? m1_if.iob_wdata : m0_if.iob_wdata;
    e_s  = e_g ? m1_if.iob_wstrb : m0_if.iob_wstrb;
    rv   = m_pend && !rst;
    exp_obs = {e_x && !e_g, e_x && e_g, e_x,
               rv && !m_pend_id, rv && m_pend_id,
               e_x ? e_a : 24'h0, e_x ? e_s : 4'h0,
               e_x ? e_wd : 32'h0, rv ? m_pend_data : 32'h0};
  endtask

  task automatic model_commit();
    if (rst) begin
      m_last = 1'b1; m_run = 0; m_pend = 1'b0;
    end else if (cke) begin
      if (e_x) begin
        m_run     = (e_g == m_last && m_run < MB) ? m_run + 1 : 1;
        m_last    = e_g;
        m_pend    = (e_s == 4'h0);
        m_pend_id = e_g;
        if (m_pend) m_pend_data = shadow[e_a[7:0]];
        else for (int b = 0; b < 4; b++)
          if (e_s[b]) shadow[e_a[7:0]][8*b +: 8] = e_wd[8*b +: 8];
      end else begin
        m_run = 0; m_pend = 1'b0;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input bit id, input bit v, input int a,
                       input logic [31:0] wd, input logic [3:0] st);
    if (id) begin
      m1_if.iob_valid = v; m1_if.iob_addr = 24'(a);
      m1_if.iob_wdata = wd; m1_if.iob_wstrb = st;
    end else begin
      m0_if.iob_valid = v; m0_if.iob_addr = 24'(a);
      m0_if.iob_wdata = wd; m0_if.iob_wstrb = st;
    end
  endtask

  task automatic do_reset();
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    cke = 1'b1;
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cke = 1'b1;
    set_m(0, 1, 3, 0, 0);
    set_m(1, 1, 5, 32'h1234, 4'hF);
    for (int i = 0; i < 2; i++) begin
      sample();
      nvec++;
      if (observe() !== exp_obs) begin
        nerr++;
        $display("FAIL reset[%0d]: got %h want %h", i, observe(), exp_obs);
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_tie();
    logic [3:0] tbl [4];
    tbl[0] = 4'b1000; tbl[1] = 4'b0110;
    tbl[2] = 4'b0001; tbl[3] = 4'b0000;
    do_reset();
    set_m(0, 1, 4, 0, 0);
    set_m(1, 1, 8, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bit a0, a1;
      sample();
      nvec++;
      if (observe() !== exp_obs) begin
        nerr++;
        $display("FAIL tie[%0d]: got %h want %h", i, observe(), exp_obs);
      end
      nvec++;
      if ({m0_if.iob_ready, m1_if.iob_ready, m0_if.iob_rvalid,
           m1_if.iob_rvalid} !== tbl[i]) begin
        nerr++;
        $display("FAIL tie_seq[%0d]: got %b%b%b%b want %b", i,
                 m0_if.iob_ready, m1_if.iob_ready, m0_if.iob_rvalid,
                 m1_if.iob_rvalid, tbl[i]);
      end
      a0 = e_x && !e_g;
      a1 = e_x && e_g;
      advance();
      if (a0) m0_if.iob_valid = 1'b0;
      if (a1) m1_if.iob_valid = 1'b0;
    end
  endtask

  task automatic test_burst();
    do_reset();
    set_m(0, 1, $urandom_range(255), 0, 0);
    set_m(1, 1, $urandom_range(255), 0, 0);
    for (int i = 0; i < 20; i++) begin
      bit want1, a0, a1;
      want1 = ((i / MB) % 2) == 1;
      sample();
      nvec++;
      if (observe() !== exp_obs) begin
        nerr++;
        $display("FAIL burst[%0d]: got %h want %h", i, observe(), exp_obs);
      end
      nvec++;
      if ({m0_if.iob_ready, m1_if.iob_ready} !== {!want1, want1}) begin
        nerr++;
        $display("FAIL burst_gnt[%0d]: got %b%b want %b%b", i,
                 m0_if.iob_ready, m1_if.iob_ready, !want1, want1);
      end
      a0 = e_x && !e_g;
      a1 = e_x && e_g;
      advance();
      if (a0) m0_if.iob_addr = 24'($urandom_range(255));
      if (a1) m1_if.iob_addr = 24'($urandom_range(255));
    end
  endtask

  task automatic test_lock_release();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_m(0, i < 2 || i == 3, 20 + i, 0, 0);
      set_m(1, i == 3, 40, 0, 0);
      sample();
      nvec++;
      if (observe() !== exp_obs) begin
        nerr++;
        $display("FAIL lockrel[%0d]: got %h want %h", i, observe(), exp_obs);
      end
      if (i == 3) begin
        nvec++;
        if ({m0_if.iob_ready, m1_if.iob_ready} !== 2'b01) begin
          nerr++;
          $display("FAIL lockrel_gnt: got %b%b want 01",
                   m0_if.iob_ready, m1_if.iob_ready);
        end
      end
      advance();
    end
  endtask

  task automatic test_partial_write();
    bd_addr = 8'h10; bd_data = 32'h11223344; bd_we = 1'b1;
    do_reset();
    bd_we = 1'b0;
    shadow[16] = 32'h11223344;
    for (int i = 0; i < 3; i++) begin
      set_m(1, i == 0, 16, 32'hAABBCCDD, 4'b0011);
      set_m(0, i == 1, 16, 0, 0);
      sample();
      nvec++;
      if (observe() !== exp_obs) begin
        nerr++;
        $display("FAIL pwrite[%0d]: got %h want %h", i, observe(), exp_obs);
      end
      if (i == 1) begin
        nvec++;
        if ({m0_if.iob_rvalid, m1_if.iob_rvalid} !== 2'b00) begin
          nerr++;
          $display("FAIL pwrite_norv: got %b%b want 00",
                   m0_if.iob_rvalid, m1_if.iob_rvalid);
        end
      end
      if (i == 2) begin
        nvec++;
        if ({m0_if.iob_rvalid, m0_if.iob_rdata} !== {1'b1, 32'h1122CCDD}) begin
          nerr++;
          $display("FAIL pwrite_data: got %b %h want 1 1122ccdd",
                   m0_if.iob_rvalid, m0_if.iob_rdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_m(0, 1, 30 + i, 0, 0);
      set_m(1, i >= 3, 50, 0, 0);
      rst = (i == 2);
      sample();
      nvec++;
      if (observe() !== exp_obs) begin
        nerr++;
        $display("FAIL rstmid[%0d]: got %h want %h", i, observe(), exp_obs);
      end
      if (i == 2) begin
        nvec++;
        if ({m0_if.iob_rvalid, m0_if.iob_ready, mem_en} !== 3'b000) begin
          nerr++;
          $display("FAIL rstmid_kill: got %b%b%b want 000",
                   m0_if.iob_rvalid, m0_if.iob_ready, mem_en);
        end
      end
      if (i == 3) begin
        nvec++;
        if ({m0_if.iob_ready, m1_if.iob_ready} !== 2'b10) begin
          nerr++;
          $display("FAIL rstmid_tie: got %b%b want 10",
                   m0_if.iob_ready, m1_if.iob_ready);
        end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_cke();
    logic [31:0] held;
    do_reset();
    set_m(0, 1, 60, 0, 0);
    set_m(1, 1, 61, 0, 0);
    held = 32'h0;
    for (int i = 0; i < 6; i++) begin
      cke = !(i >= 1 && i <= 3);
      sample();
      nvec++;
      if (observe() !== exp_obs) begin
        nerr++;
        $display("FAIL cke[%0d]: got %h want %h", i, observe(), exp_obs);
      end
      if (i >= 1 && i <= 3) begin
        nvec++;
        if ({m0_if.iob_ready, m1_if.iob_ready, mem_en, m0_if.iob_rvalid,
             m0_if.iob_rdata} !== {4'b0001, pat(60)}) begin
          nerr++;
          $display("FAIL cke_hold[%0d]: got %b%b%b%b %h want 0001 %h", i,
                   m0_if.iob_ready, m1_if.iob_ready, mem_en,
                   m0_if.iob_rvalid, m0_if.iob_rdata, pat(60));
        end
      end
      if (i == 4) begin
        nvec++;
        if ({m0_if.iob_ready, m1_if.iob_ready} !== 2'b10) begin
          nerr++;
          $display("FAIL cke_resume: got %b%b want 10",
                   m0_if.iob_ready, m1_if.iob_ready);
        end
      end
      advance();
    end
    cke = 1'b1;
  endtask

  task automatic test_random();
    bit p0, p1, a0, a1;
    p0 = 0; p1 = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(9) < 6) begin
        p0 = 1;
        set_m(0, 1, $urandom_range(15), $urandom,
              $urandom_range(1) ? 4'($urandom) : 4'h0);
      end
      if (!p1 && $urandom_range(9) < 6) begin
        p1 = 1;
        set_m(1, 1, $urandom_range(15), $urandom,
              $urandom_range(1) ? 4'($urandom) : 4'h0);
      end
      cke = $urandom_range(9) != 0;
      rst = $urandom_range(49) == 0;
      sample();
      nvec++;
      if (observe() !== exp_obs) begin
        nerr++;
        $display("FAIL rand[%0d]: got %h want %h", i, observe(), exp_obs);
      end
      a0 = e_x && !e_g;
      a1 = e_x && e_g;
      advance();
      if (a0) begin p0 = 0; m0_if.iob_valid = 1'b0; end
      if (a1) begin p1 = 0; m1_if.iob_valid = 1'b0; end
    end
    rst = 1'b0;
    cke = 1'b1;
  endtask

  initial begin
    nvec = 0; nerr = 0;
    m_last = 1'b1; m_run = 0; m_pend = 1'b0;
    m_pend_id = 1'b0; m_pend_data = 32'h0;
    bd_we = 1'b0; bd_addr = 8'h0; bd_data = 32'h0;
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    cke = 1'b1;
    rst = 1'b1;
    fill = 1'b1;
    @(posedge clk);
    #1;
    fill = 1'b0;
    test_reset();
    test_tie();
    test_burst();
    test_lock_release();
    test_partial_write();
    test_reset_midburst();
    test_cke();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
